// File: rtl/ufi_arb_pkg.sv
// ----------------------------------------------------------------------------
// ufi_arb_pkg
//   Shared definitions for the UfiBus RAM-port arbiter.
//   - arbState_t : arbiter FSM states (IDLE turnaround, GRANT ownership)
//   - lpVtb/lpAtb/lpMcs : master index assignment on iReq/iBeat/iUrgent/oGnt
// ----------------------------------------------------------------------------
package ufi_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

    // Master positions on the request / grant vectors
    localparam int lpVtb = 0;   // video DMA
    localparam int lpAtb = 1;   // audio DMA
    localparam int lpMcs = 2;   // CPU

endpackage

// File: rtl/ufi_rr_picker.sv
// ----------------------------------------------------------------------------
// ufi_rr_picker
//   Combinational rotate-priority encoder. Searches the request vector
//   starting at the position just after iPtr and wrapping around, so the
//   master named by iPtr (the previous winner) has the lowest priority.
//
// Ports
//   iReq  in   pMasterNum  request vector
//   iPtr  in   pIdxW       index of the previous winner
//   oGnt  out  pMasterNum  one-hot winner (zero when no request)
//   oIdx  out  pIdxW       index of the winner (zero when no request)
//   oAny  out  1           at least one request present
// ----------------------------------------------------------------------------
module ufi_rr_picker #(
    parameter int pMasterNum = 3,
    parameter int pIdxW      = 3
) (
    input  logic [pMasterNum-1:0] iReq,
    input  logic [pIdxW-1:0]      iPtr,
    output logic [pMasterNum-1:0] oGnt,
    output logic [pIdxW-1:0]      oIdx,
    output logic                  oAny
);

    always_comb begin
        int  cand;
        logic found;
        oGnt  = '0;
        oIdx  = '0;
        found = 1'b0;
        cand  = 0;
        // Offset runs 1..pMasterNum so the pointer position itself is tried last
        for (int k = 1; k <= pMasterNum; k++) begin
            cand = (int'(iPtr) + k) % pMasterNum;
            if (!found && iReq[cand]) begin
                found      = 1'b1;
                oGnt[cand] = 1'b1;
                oIdx       = pIdxW'(cand);
            end
        end
    end

    assign oAny = |iReq;

endmodule

// File: rtl/ufi_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ufi_bus_arbiter
//   Shares the single UfiBus RAM slave port between Vtb, Atb and Mcs.
//   One master owns the bus at a time; owners are chosen round-robin, an
//   urgent request (lowest index first) overrides the rotation, and every
//   grant is capped at pMaxBurst accepted beats. At least one idle cycle
//   (oGnt=0) separates consecutive grants for bus turnaround.
//
// Ports
//   iUfiClk     in   1             bus clock
//   iUfiRst     in   1             asynchronous reset, active low
//   iReq        in   pMasterNum    per-master request level
//   iBeat       in   pMasterNum    per-master beat strobe
//   iUrgent     in   pMasterNum    per-master urgent flag
//   iSlvRdy     in   1             RAM slave ready
//   iStarveClr  in   1             pulse, clears all starvation flags
//   oGnt        out  pMasterNum    registered one-hot grant
//   oGntId      out  pUfiIdNumber  index of granted master (valid with oBusVd)
//   oBusVd      out  1             grant active
//   oMUfiRdy    out  pMasterNum    per-master ready = oGnt & iSlvRdy
//   oStarve     out  pMasterNum    sticky starvation flags
// ----------------------------------------------------------------------------
module ufi_bus_arbiter
    import ufi_arb_pkg::*;
#(
    parameter int pMasterNum   = 3,
    parameter int pUfiIdNumber = 3,
    parameter int pMaxBurst    = 64,
    parameter int pMinBurst    = 8,
    parameter int pStarveLimit = 1024
) (
    input  logic                    iUfiClk,
    input  logic                    iUfiRst,
    input  logic [pMasterNum-1:0]   iReq,
    input  logic [pMasterNum-1:0]   iBeat,
    input  logic [pMasterNum-1:0]   iUrgent,
    input  logic                    iSlvRdy,
    input  logic                    iStarveClr,
    output logic [pMasterNum-1:0]   oGnt,
    output logic [pUfiIdNumber-1:0] oGntId,
    output logic                    oBusVd,
    output logic [pMasterNum-1:0]   oMUfiRdy,
    output logic [pMasterNum-1:0]   oStarve
);

    localparam int lpBeatW = $clog2(pMaxBurst + 1);
    localparam int lpWaitW = $clog2(pStarveLimit + 1);

    // Saturating increment of the per-grant beat counter
    function automatic logic [lpBeatW-1:0] satIncBeat(input logic [lpBeatW-1:0] cnt,
                                                      input logic inc);
        if (inc && (cnt != lpBeatW'(pMaxBurst)))
            return cnt + lpBeatW'(1);
        return cnt;
    endfunction

    // Saturating increment of a starvation wait counter
    function automatic logic [lpWaitW-1:0] satIncWait(input logic [lpWaitW-1:0] cnt);
        if (cnt != lpWaitW'(pStarveLimit))
            return cnt + lpWaitW'(1);
        return cnt;
    endfunction

    arbState_t                state, stateNext;
    logic [pMasterNum-1:0]    gntNext;
    logic [pUfiIdNumber-1:0]  gntIdNext;
    logic                     busVdNext;
    logic [pUfiIdNumber-1:0]  rrPtr, rrPtrNext;
    logic [lpBeatW-1:0]       beatCnt, beatCntNext, beatInc;

    logic [pMasterNum-1:0]    rrGnt;
    logic [pUfiIdNumber-1:0]  rrIdx;
    logic                     anyReq;

    logic [pMasterNum-1:0]    urgReq;
    logic [pMasterNum-1:0]    urgGnt;
    logic [pUfiIdNumber-1:0]  urgIdx;
    logic                     urgAny;

    logic                     ownReq, ownUrgent, beatAcc, otherUrgent, release_;

    logic [lpWaitW-1:0]       waitCnt  [pMasterNum];
    logic [lpWaitW-1:0]       waitNext [pMasterNum];
    logic [pMasterNum-1:0]    waiting, starveSet, starveNext;

    ufi_rr_picker #(
        .pMasterNum (pMasterNum),
        .pIdxW      (pUfiIdNumber)
    ) uRrPicker (
        .iReq (iReq),
        .iPtr (rrPtr),
        .oGnt (rrGnt),
        .oIdx (rrIdx),
        .oAny (anyReq)
    );

    // Urgent override: lowest-index urgent requester wins outright
    assign urgReq = iReq & iUrgent;

    always_comb begin
        urgGnt = '0;
        urgIdx = '0;
        urgAny = 1'b0;
        for (int i = 0; i < pMasterNum; i++) begin
            if (!urgAny && urgReq[i]) begin
                urgAny    = 1'b1;
                urgGnt[i] = 1'b1;
                urgIdx    = pUfiIdNumber'(i);
            end
        end
    end

    // Owner-relative signals use the one-hot grant as a mask
    assign ownReq      = |(iReq & oGnt);
    assign ownUrgent   = |(iUrgent & oGnt);
    assign beatAcc     = (|(iBeat & oGnt)) & iSlvRdy;
    assign otherUrgent = |(urgReq & ~oGnt);
    assign beatInc     = satIncBeat(beatCnt, beatAcc);

    // Preemption looks at beats already completed before this cycle
    assign release_ = !ownReq
                   || (beatInc == lpBeatW'(pMaxBurst))
                   || (otherUrgent && !ownUrgent && (beatCnt >= lpBeatW'(pMinBurst)));

    always_comb begin
        stateNext   = state;
        gntNext     = oGnt;
        gntIdNext   = oGntId;
        busVdNext   = oBusVd;
        rrPtrNext   = rrPtr;
        beatCntNext = beatCnt;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext   = GRANT;
                    busVdNext   = 1'b1;
                    beatCntNext = '0;
                    if (urgAny) begin
                        gntNext   = urgGnt;
                        gntIdNext = urgIdx;
                        rrPtrNext = urgIdx;
                    end else begin
                        gntNext   = rrGnt;
                        gntIdNext = rrIdx;
                        rrPtrNext = rrIdx;
                    end
                end
            end
            GRANT: begin
                beatCntNext = beatInc;
                if (release_) begin
                    stateNext = IDLE;
                    gntNext   = '0;
                    busVdNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                gntNext   = '0;
                busVdNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iUfiClk or negedge iUfiRst) begin
        if (!iUfiRst) begin
            state   <= IDLE;
            oGnt    <= '0;
            oGntId  <= '0;
            oBusVd  <= 1'b0;
            rrPtr   <= pUfiIdNumber'(pMasterNum - 1);
            beatCnt <= '0;
        end else begin
            state   <= stateNext;
            oGnt    <= gntNext;
            oGntId  <= gntIdNext;
            oBusVd  <= busVdNext;
            rrPtr   <= rrPtrNext;
            beatCnt <= beatCntNext;
        end
    end

    assign oMUfiRdy = oGnt & {pMasterNum{iSlvRdy}};

    // Starvation: count cycles spent requesting without a grant. The flag is
    // set only on the cycle the counter reaches the limit, so a clear pulse
    // is not immediately overridden by a counter already sitting saturated.
    assign waiting = iReq & ~oGnt;

    always_comb begin
        for (int i = 0; i < pMasterNum; i++) begin
            waitNext[i]  = waiting[i] ? satIncWait(waitCnt[i]) : '0;
            starveSet[i] = waiting[i] && (waitCnt[i] == lpWaitW'(pStarveLimit - 1));
        end
        starveNext = (iStarveClr ? '0 : oStarve) | starveSet;
    end

    always_ff @(posedge iUfiClk or negedge iUfiRst) begin
        if (!iUfiRst) begin
            for (int i = 0; i < pMasterNum; i++)
                waitCnt[i] <= '0;
            oStarve <= '0;
        end else begin
            for (int i = 0; i < pMasterNum; i++)
                waitCnt[i] <= waitNext[i];
            oStarve <= starveNext;
        end
    end

endmodule

// File: tb/tb_ufi_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ufi_bus_arbiter
//   Self-checking bench for ufi_bus_arbiter: directed scenarios with fixed
//   expectations plus a randomized run compared against a cycle-level
//   behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_ufi_bus_arbiter;
    import ufi_arb_pkg::*;

    localparam int N   = 3;
    localparam int MAX = 64;
    localparam int MIN = 8;
    localparam int LIM = 16;

    logic         iUfiClk    = 1'b0;
    logic         iUfiRst    = 1'b0;
    logic [N-1:0] iReq       = '0;
    logic [N-1:0] iBeat      = '0;
    logic [N-1:0] iUrgent    = '0;
    logic         iSlvRdy    = 1'b0;
    logic         iStarveClr = 1'b0;
    logic [N-1:0] oGnt;
    logic [2:0]   oGntId;
    logic         oBusVd;
    logic [N-1:0] oMUfiRdy;
    logic [N-1:0] oStarve;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         mOwner;        // -1 when the bus is free
    int         mBeats;
    int         mLast;
    int         mWait [N];
    logic [N-1:0] mStarve;

    ufi_bus_arbiter #(
        .pMasterNum   (N),
        .pUfiIdNumber (3),
        .pMaxBurst    (MAX),
        .pMinBurst    (MIN),
        .pStarveLimit (LIM)
    ) dut (
        .iUfiClk    (iUfiClk),
        .iUfiRst    (iUfiRst),
        .iReq       (iReq),
        .iBeat      (iBeat),
        .iUrgent    (iUrgent),
        .iSlvRdy    (iSlvRdy),
        .iStarveClr (iStarveClr),
        .oGnt       (oGnt),
        .oGntId     (oGntId),
        .oBusVd     (oBusVd),
        .oMUfiRdy   (oMUfiRdy),
        .oStarve    (oStarve)
    );

    always #5 iUfiClk = ~iUfiClk;

    function void modelReset();
        mOwner  = -1;
        mBeats  = 0;
        mLast   = N - 1;
        mStarve = '0;
        for (int i = 0; i < N; i++) mWait[i] = 0;
    endfunction

    // One clock edge of the arbitration rules, applied to the current inputs
    function void modelStep();
        int           prev;
        int           w;
        int           nb;
        bit           rel;
        logic [N-1:0] setv;
        if (!iUfiRst) begin
            modelReset();
            return;
        end
        prev = mOwner;
        setv = '0;
        for (int i = 0; i < N; i++) begin
            if (!iReq[i] || prev == i) begin
                mWait[i] = 0;
            end else if (mWait[i] < LIM) begin
                mWait[i] = mWait[i] + 1;
                if (mWait[i] == LIM) setv[i] = 1'b1;
            end
        end
        mStarve = (iStarveClr ? '0 : mStarve) | setv;
        if (prev < 0) begin
            if (iReq != '0) begin
                w = -1;
                if ((iReq & iUrgent) != '0) begin
                    for (int i = 0; i < N; i++)
                        if (w < 0 && iReq[i] && iUrgent[i]) w = i;
                end else begin
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && iReq[(mLast + k) % N]) w = (mLast + k) % N;
                end
                mOwner = w;
                mLast  = w;
                mBeats = 0;
            end
        end else begin
            nb = mBeats + ((iBeat[prev] && iSlvRdy) ? 1 : 0);
            if (nb > MAX) nb = MAX;
            rel = !iReq[prev] || (nb == MAX);
            for (int j = 0; j < N; j++)
                if (j != prev && iReq[j] && iUrgent[j] && !iUrgent[prev] && mBeats >= MIN)
                    rel = 1'b1;
            mBeats = nb;
            if (rel) mOwner = -1;
        end
    endfunction

    task automatic stepClk();
        @(posedge iUfiClk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        iUfiRst    = 1'b0;
        iReq       = '0;
        iBeat      = '0;
        iUrgent    = '0;
        iSlvRdy    = 1'b0;
        iStarveClr = 1'b0;
        modelReset();
        repeat (2) stepClk();
        iUfiRst = 1'b1;
    endtask

    task automatic test_reset();
        iUfiRst = 1'b0;
        iReq    = 3'b111;
        iBeat   = 3'b111;
        iSlvRdy = 1'b1;
        modelReset();
        for (int c = 0; c < 4; c++) begin
            @(negedge iUfiClk);
            checks++;
            if (oGnt !== 3'b000 || oBusVd !== 1'b0 || oStarve !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: oGnt=%b oBusVd=%b oStarve=%b, expected 000/0/000",
                         c, oGnt, oBusVd, oStarve);
            end
            stepClk();
        end
        iUfiRst = 1'b1;
        stepClk();
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b001 || oGntId !== 3'd0 || oBusVd !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: oGnt=%b oGntId=%0d oBusVd=%b, expected 001/0/1",
                     oGnt, oGntId, oBusVd);
        end
        stepClk();
        stepClk();
        // Asynchronous reset in the middle of a grant
        #2;
        iUfiRst = 1'b0;
        modelReset();
        #1;
        checks++;
        if (oGnt !== 3'b000 || oBusVd !== 1'b0 || oMUfiRdy !== 3'b000 || oGntId !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: oGnt=%b oBusVd=%b oMUfiRdy=%b oGntId=%0d, expected all zero",
                     oGnt, oBusVd, oMUfiRdy, oGntId);
        end
        stepClk();
    endtask

    task automatic test_round_robin();
        int           order [4] = '{0, 1, 2, 0};
        logic [N-1:0] e;
        doReset();
        iReq    = 3'b111;
        iBeat   = 3'b111;
        iUrgent = 3'b000;
        iSlvRdy = 1'b1;
        for (int g = 0; g < 4; g++) begin
            @(negedge iUfiClk);
            checks++;
            if (oGnt !== 3'b000 || oBusVd !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle before grant %0d: oGnt=%b oBusVd=%b, expected 000/0", g, oGnt, oBusVd);
            end
            stepClk();
            e = 3'b001 << order[g];
            for (int k = 0; k < ((g == 3) ? 4 : MAX); k++) begin
                @(negedge iUfiClk);
                checks++;
                if (oGnt !== e || oGntId !== 3'(order[g]) || oBusVd !== 1'b1 || oMUfiRdy !== e) begin
                    errors++;
                    $display("FAIL rr_grant %0d beat %0d: oGnt=%b oGntId=%0d oBusVd=%b oMUfiRdy=%b, expected %b/%0d/1/%b",
                             g, k, oGnt, oGntId, oBusVd, oMUfiRdy, e, order[g], e);
                end
                stepClk();
            end
        end
    endtask

    task automatic test_release_on_drop();
        doReset();
        iReq    = 3'b010;
        iBeat   = 3'b010;
        iSlvRdy = 1'b1;
        stepClk();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) iReq = 3'b000;
            @(negedge iUfiClk);
            checks++;
            if (oGnt !== 3'b010 || oGntId !== 3'd1) begin
                errors++;
                $display("FAIL drop_grant beat %0d: oGnt=%b oGntId=%0d, expected 010/1", k, oGnt, oGntId);
            end
            stepClk();
        end
        iBeat = 3'b000;
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b000 || oBusVd !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: oGnt=%b oBusVd=%b, expected 000/0", oGnt, oBusVd);
        end
        stepClk();
    endtask

    task automatic test_urgent_preempt();
        doReset();
        iReq    = 3'b100;
        iBeat   = 3'b100;
        iSlvRdy = 1'b1;
        stepClk();
        for (int k = 0; k < 7; k++) stepClk();
        // Urgent arrives with 7 beats done: below the minimum, no preemption yet
        iReq    = 3'b101;
        iUrgent = 3'b001;
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b100) begin
            errors++;
            $display("FAIL urg_before_min: oGnt=%b, expected 100", oGnt);
        end
        stepClk();
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b100 || oGntId !== 3'd2) begin
            errors++;
            $display("FAIL urg_at_min: oGnt=%b oGntId=%0d, expected 100/2", oGnt, oGntId);
        end
        stepClk();
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b000 || oBusVd !== 1'b0) begin
            errors++;
            $display("FAIL urg_idle: oGnt=%b oBusVd=%b, expected 000/0", oGnt, oBusVd);
        end
        stepClk();
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b001 || oGntId !== 3'd0 || oBusVd !== 1'b1) begin
            errors++;
            $display("FAIL urg_new_owner: oGnt=%b oGntId=%0d oBusVd=%b, expected 001/0/1", oGnt, oGntId, oBusVd);
        end
        stepClk();
    endtask

    task automatic test_slave_stall();
        doReset();
        iReq    = 3'b001;
        iBeat   = 3'b001;
        iSlvRdy = 1'b1;
        stepClk();
        for (int k = 0; k < 3; k++) stepClk();
        iSlvRdy = 1'b0;
        iBeat   = 3'b111;
        for (int k = 0; k < 20; k++) begin
            @(negedge iUfiClk);
            checks++;
            if (oGnt !== 3'b001 || oMUfiRdy !== 3'b000) begin
                errors++;
                $display("FAIL stall cyc %0d: oGnt=%b oMUfiRdy=%b, expected 001/000", k, oGnt, oMUfiRdy);
            end
            stepClk();
        end
        iSlvRdy = 1'b1;
        // Three beats done before the stall; exactly MAX-3 more keep the grant
        for (int k = 0; k < MAX - 3; k++) begin
            @(negedge iUfiClk);
            checks++;
            if (oGnt !== 3'b001 || oMUfiRdy !== 3'b001) begin
                errors++;
                $display("FAIL stall_resume beat %0d: oGnt=%b oMUfiRdy=%b, expected 001/001", k, oGnt, oMUfiRdy);
            end
            stepClk();
        end
        @(negedge iUfiClk);
        checks++;
        if (oGnt !== 3'b000 || oBusVd !== 1'b0) begin
            errors++;
            $display("FAIL stall_cap_release: oGnt=%b oBusVd=%b, expected 000/0", oGnt, oBusVd);
        end
        stepClk();
    endtask

    task automatic test_starve();
        doReset();
        iReq    = 3'b011;
        iUrgent = 3'b001;
        iBeat   = 3'b001;
        iSlvRdy = 1'b1;
        for (int k = 0; k < LIM; k++) begin
            @(negedge iUfiClk);
            checks++;
            if (oStarve !== 3'b000) begin
                errors++;
                $display("FAIL starve_early wait %0d: oStarve=%b, expected 000", k, oStarve);
            end
            stepClk();
        end
        @(negedge iUfiClk);
        checks++;
        if (oStarve !== 3'b010) begin
            errors++;
            $display("FAIL starve_set: oStarve=%b, expected 010", oStarve);
        end
        iStarveClr = 1'b1;
        stepClk();
        iStarveClr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge iUfiClk);
            checks++;
            if (oStarve !== 3'b000) begin
                errors++;
                $display("FAIL starve_clear cyc %0d: oStarve=%b, expected 000", k, oStarve);
            end
            stepClk();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] eGnt;
        doReset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) iReq[i]    = ~iReq[i];
                if ($urandom_range(15) == 0) iUrgent[i] = ~iUrgent[i];
                iBeat[i] = ($urandom_range(3) != 0);
            end
            iSlvRdy    = ($urandom_range(7) != 0);
            iStarveClr = ($urandom_range(39) == 0);
            @(negedge iUfiClk);
            eGnt = (mOwner < 0) ? 3'b000 : (3'b001 << mOwner);
            checks++;
            if (oGnt !== eGnt || oBusVd !== (mOwner >= 0) || oMUfiRdy !== (eGnt & {N{iSlvRdy}})) begin
                errors++;
                $display("FAIL rand_grant cyc %0d: oGnt=%b oBusVd=%b oMUfiRdy=%b, expected %b/%b/%b",
                         c, oGnt, oBusVd, oMUfiRdy, eGnt, (mOwner >= 0), eGnt & {N{iSlvRdy}});
            end
            checks++;
            if (oStarve !== mStarve) begin
                errors++;
                $display("FAIL rand_starve cyc %0d: oStarve=%b, expected %b", c, oStarve, mStarve);
            end
            if (mOwner >= 0) begin
                checks++;
                if (oGntId !== 3'(mOwner)) begin
                    errors++;
                    $display("FAIL rand_id cyc %0d: oGntId=%0d, expected %0d", c, oGntId, mOwner);
                end
            end
            stepClk();
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_round_robin();
        test_release_on_drop();
        test_urgent_preempt();
        test_slave_stall();
        test_starve();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
